dbg_uart_bridge: RTL and testbench

DBG_UART_BRIDGE -- requirements
Module: dbg_uart_bridge

---
 rtl/dbg_uart_pkg.sv | 37 +++
 rtl/dbg_uart_tx.sv | 110 +++++++++++
 rtl/dbg_uart_bridge.sv | 165 ++++++++++++++++
 tb/tb_dbg_uart_bridge.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_uart_pkg.sv
// Shared types and helpers for the debug UART bridge.
//
// Contents:
//   DEFAULT_CLKS_PER_BIT : default clk cycles per UART bit.
//   rx_state_t           : receiver FSM states (R_IDLE, R_START, R_DATA, R_STOP).
//   tx_state_t           : transmitter FSM states (T_IDLE, T_START, T_DATA, T_STOP).
//   bit_cnt_width()      : width of a per-bit cycle counter able to hold
//                          CLKS_PER_BIT-1 without wrapping.
package dbg_uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 104;

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    T_IDLE,
    T_START,
    T_DATA,
    T_STOP
  } tx_state_t;

  // The counters only ever hold values up to CLKS_PER_BIT-1, so
  // ceil(log2(CLKS_PER_BIT)) bits are always enough.
  function automatic int bit_cnt_width(input int clks_per_bit);
    return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
  endfunction

  // Counter width for the default bit period; modules compute their own
  // value from their CLKS_PER_BIT with the same function.
  localparam int DEFAULT_CNT_W = bit_cnt_width(DEFAULT_CLKS_PER_BIT);

endpackage

// File: rtl/dbg_uart_tx.sv
// UART serializer: 8N1 frames, LSB first, CLKS_PER_BIT clk cycles per bit.
//
// Ports:
//   clk          : system clock, rising edge.
//   reset        : synchronous, active-high.
//   data_tx      : byte to send, captured when a request is accepted.
//   data_tx_seq  : toggled by the requester to ask for a frame.
//   data_tx_ack  : copied from data_tx_seq once the frame is on the wire.
//   tx           : serial output, idle high.
module dbg_uart_tx
  import dbg_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_tx,
  input  logic       data_tx_seq,
  output logic       data_tx_ack,
  output logic       tx
);

  localparam int CNT_W = bit_cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       idx, idx_n;
  logic [7:0]       shreg, shreg_n;
  logic             tx_n;
  logic             ack_n;

  // State and datapath registers. Reset parks the line high and makes the
  // handshake look complete, so nothing is pending coming out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= T_IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      tx          <= 1'b1;
      data_tx_ack <= data_tx_seq;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      shreg       <= shreg_n;
      tx          <= tx_n;
      data_tx_ack <= ack_n;
    end
  end

  // Next-state logic. tx is registered, so each branch decides what the line
  // shows from the next edge. The stop bit spends CLKS_PER_BIT-1 cycles in
  // T_STOP and its final cycle in T_IDLE with the ack already visible; a
  // request seen in that cycle starts the next frame with no idle gap.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    tx_n    = tx;
    ack_n   = data_tx_ack;
    case (state)
      T_IDLE: begin
        if (data_tx_seq != data_tx_ack) begin
          shreg_n = data_tx;
          tx_n    = 1'b0;
          cnt_n   = BIT_LAST;
          state_n = T_START;
        end
      end
      T_START: begin
        if (cnt == '0) begin
          tx_n    = shreg[0];
          cnt_n   = BIT_LAST;
          idx_n   = '0;
          state_n = T_DATA;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      T_DATA: begin
        if (cnt == '0) begin
          cnt_n = BIT_LAST;
          if (idx == 3'd7) begin
            tx_n    = 1'b1;
            state_n = T_STOP;
          end else begin
            shreg_n = {1'b1, shreg[7:1]};
            tx_n    = shreg[1];
            idx_n   = idx + 3'd1;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      T_STOP: begin
        if (cnt == CNT_W'(1)) begin
          ack_n   = data_tx_seq;
          state_n = T_IDLE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = T_IDLE;
    endcase
  end

endmodule

// File: rtl/dbg_uart_bridge.sv
// Debug UART bridge: a receiver and a transmitter with toggle/ack
// handshakes towards the host logic. RX lives here, TX is dbg_uart_tx.
//
// Ports:
//   clk           : system clock, rising edge.
//   reset         : synchronous, active-high.
//   rx            : asynchronous serial input, idle high.
//   tx            : serial output, idle high.
//   data_rx       : last published byte.
//   data_rx_valid : published byte had a good (high) stop bit.
//   data_rx_seq   : toggles when a new byte is published.
//   data_rx_ack   : consumer sets equal to data_rx_seq when finished.
//   data_tx       : byte to transmit.
//   data_tx_seq   : toggle to request a transmission.
//   data_tx_ack   : follows data_tx_seq once the frame has been sent.
//   rx_overrun    : sticky, set when a byte arrived while the last was unacked.
module dbg_uart_bridge
  import dbg_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       tx,
  output logic [7:0] data_rx,
  output logic       data_rx_valid,
  output logic       data_rx_seq,
  input  logic       data_rx_ack,
  input  logic [7:0] data_tx,
  input  logic       data_tx_seq,
  output logic       data_tx_ack,
  output logic       rx_overrun
);

  localparam int CNT_W = bit_cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             rx_meta, rx_sync, rx_prev;
  rx_state_t        rx_state, rx_state_n;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]       rx_idx, rx_idx_n;
  logic [7:0]       rx_shift, rx_shift_n;
  logic             rx_done;

  // Two-flop synchronizer for the asynchronous rx pin, plus one more flop of
  // history so a falling edge can be spotted on the synchronized value. All
  // of them reset to the idle level so no false start bit appears.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= R_IDLE;
    end else begin
      rx_state <= rx_state_n;
    end
  end

  // Receiver next-state logic. After the falling edge we wait half a bit to
  // land in the middle of the start bit, then sample every full bit period.
  // rx_done marks the stop-bit sample; the FSM is back in R_IDLE next cycle.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_idx_n   = rx_idx;
    rx_shift_n = rx_shift;
    rx_done    = 1'b0;
    case (rx_state)
      R_IDLE: begin
        if (rx_prev && !rx_sync) begin
          rx_cnt_n   = HALF_LAST;
          rx_state_n = R_START;
        end
      end
      R_START: begin
        if (rx_cnt == '0) begin
          if (rx_sync) begin
            rx_state_n = R_IDLE;
          end else begin
            rx_cnt_n   = BIT_LAST;
            rx_idx_n   = '0;
            rx_state_n = R_DATA;
          end
        end else begin
          rx_cnt_n = rx_cnt - CNT_W'(1);
        end
      end
      R_DATA: begin
        if (rx_cnt == '0) begin
          rx_shift_n = {rx_sync, rx_shift[7:1]};
          rx_cnt_n   = BIT_LAST;
          if (rx_idx == 3'd7) begin
            rx_state_n = R_STOP;
          end else begin
            rx_idx_n = rx_idx + 3'd1;
          end
        end else begin
          rx_cnt_n = rx_cnt - CNT_W'(1);
        end
      end
      R_STOP: begin
        if (rx_cnt == '0) begin
          rx_done    = 1'b1;
          rx_state_n = R_IDLE;
        end else begin
          rx_cnt_n = rx_cnt - CNT_W'(1);
        end
      end
      default: rx_state_n = R_IDLE;
    endcase
  end

  // Receiver datapath and host-side outputs. A finished byte is published
  // only when the consumer has caught up (seq == ack); otherwise it is
  // dropped and the sticky overrun flag records the loss, which keeps the
  // published byte stable for as long as the consumer holds it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_cnt        <= '0;
      rx_idx        <= '0;
      rx_shift      <= '0;
      data_rx       <= '0;
      data_rx_valid <= 1'b0;
      data_rx_seq   <= data_rx_ack;
      rx_overrun    <= 1'b0;
    end else begin
      rx_cnt   <= rx_cnt_n;
      rx_idx   <= rx_idx_n;
      rx_shift <= rx_shift_n;
      if (rx_done) begin
        if (data_rx_seq == data_rx_ack) begin
          data_rx       <= rx_shift;
          data_rx_valid <= rx_sync;
          data_rx_seq   <= ~data_rx_seq;
        end else begin
          rx_overrun <= 1'b1;
        end
      end
    end
  end

  dbg_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk        (clk),
    .reset      (reset),
    .data_tx    (data_tx),
    .data_tx_seq(data_tx_seq),
    .data_tx_ack(data_tx_ack),
    .tx         (tx)
  );

endmodule

// File: tb/tb_dbg_uart_bridge.sv
// Self-checking bench for dbg_uart_bridge at 16 clk cycles per bit.
// A behavioural model predicts the line level and handshake outputs from
// frame start times; a compare process checks them every cycle, and the
// directed tests add hand-computed literal checks.
module tb_dbg_uart_bridge;
  import dbg_uart_pkg::*;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       tx;
  logic [7:0] data_rx;
  logic       data_rx_valid;
  logic       data_rx_seq;
  logic       data_rx_ack;
  logic [7:0] data_tx;
  logic       data_tx_seq;
  logic       data_tx_ack;
  logic       rx_overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model state: RX outputs before/after the current frame's publish window,
  // and the current TX frame's start cycle, byte and sequence value.
  bit         check_en = 1'b0;
  int         rx_lo = -1;
  int         rx_hi = -1;
  logic       rx_old_seq, rx_new_seq;
  logic [7:0] rx_old_data, rx_new_data;
  logic       rx_old_valid, rx_new_valid;
  logic       rx_old_ovr, rx_new_ovr;
  bit         tx_active = 1'b0;
  int         tx_start = 0;
  logic [7:0] tx_byte = '0;
  logic       tx_seqval = 1'b0;
  logic       tx_prev_ack = 1'b0;
  int         seq_toggles = 0;
  logic       seq_seen = 1'b0;

  dbg_uart_bridge #(
    .CLKS_PER_BIT(N)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .tx           (tx),
    .data_rx      (data_rx),
    .data_rx_valid(data_rx_valid),
    .data_rx_seq  (data_rx_seq),
    .data_rx_ack  (data_rx_ack),
    .data_tx      (data_tx),
    .data_tx_seq  (data_tx_seq),
    .data_tx_ack  (data_tx_ack),
    .rx_overrun   (rx_overrun)
  );

  // Free-running clock and a cycle counter used as the model's time base.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case something hangs despite the bounded waits.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
               name, cyc, actual, expected);
    end
  endtask

  // Line level of the model transmitter: bit k of a frame covers cycles
  // start+k*N .. start+k*N+N-1; bit 0 is the start bit, 9 the stop bit.
  function automatic logic exp_tx_level(input int c);
    int k;
    if (!tx_active || c < tx_start) return 1'b1;
    k = (c - tx_start) / N;
    if (k == 0) return 1'b0;
    if (k <= 8) return tx_byte[k-1];
    return 1'b1;
  endfunction

  // The ack is visible during the last cycle of the stop bit.
  function automatic logic exp_tx_ack(input int c);
    if (tx_active && c >= tx_start + 10 * N - 1) return tx_seqval;
    return tx_prev_ack;
  endfunction

  // Every-cycle comparison against the model. Inside an RX publish window
  // the RX outputs may legitimately be either old or new, so they are only
  // checked before and after it.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("tx_line", 32'(tx), 32'(exp_tx_level(cyc)));
      checkOutput("tx_ack", 32'(data_tx_ack), 32'(exp_tx_ack(cyc)));
      if (cyc < rx_lo) begin
        checkOutput("rx_seq", 32'(data_rx_seq), 32'(rx_old_seq));
        checkOutput("rx_data", 32'(data_rx), 32'(rx_old_data));
        checkOutput("rx_valid", 32'(data_rx_valid), 32'(rx_old_valid));
        checkOutput("rx_overrun", 32'(rx_overrun), 32'(rx_old_ovr));
      end else if (cyc > rx_hi) begin
        checkOutput("rx_seq", 32'(data_rx_seq), 32'(rx_new_seq));
        checkOutput("rx_data", 32'(data_rx), 32'(rx_new_data));
        checkOutput("rx_valid", 32'(data_rx_valid), 32'(rx_new_valid));
        checkOutput("rx_overrun", 32'(rx_overrun), 32'(rx_new_ovr));
      end
    end
  end

  // Counts every change of data_rx_seq so tests can check toggle counts.
  always @(negedge clk) begin
    if (data_rx_seq !== seq_seen) seq_toggles++;
    seq_seen = data_rx_seq;
  end

  // Advance n cycles; stimulus always changes 2 time units after a negedge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  // Hold reset for n cycles, check the reset values, release and re-seed the
  // model with the idle, nothing-pending state.
  task automatic do_reset(input int n);
    check_en = 1'b0;
    reset = 1'b1;
    step(n);
    checkOutput("rst_tx", 32'(tx), 32'd1);
    checkOutput("rst_data_rx", 32'(data_rx), 32'd0);
    checkOutput("rst_valid", 32'(data_rx_valid), 32'd0);
    checkOutput("rst_overrun", 32'(rx_overrun), 32'd0);
    checkOutput("rst_rx_seq_eq_ack", 32'(data_rx_seq == data_rx_ack), 32'd1);
    checkOutput("rst_tx_ack_eq_seq", 32'(data_tx_ack == data_tx_seq), 32'd1);
    reset = 1'b0;
    rx_old_seq = data_rx_ack;  rx_new_seq = data_rx_ack;
    rx_old_data = '0;          rx_new_data = '0;
    rx_old_valid = 1'b0;       rx_new_valid = 1'b0;
    rx_old_ovr = 1'b0;         rx_new_ovr = 1'b0;
    rx_lo = -1;
    rx_hi = -1;
    tx_active = 1'b0;
    tx_prev_ack = data_tx_seq;
    step(1);
    check_en = 1'b1;
  endtask

  // Send one RX frame and predict its effect: publish if the consumer has
  // caught up, otherwise flag an overrun. The publish must land somewhere
  // between the start of the stop bit and shortly after its end.
  task automatic applyStimulus(input logic [7:0] b, input logic stop);
    int s;
    s = cyc;
    rx_old_seq = rx_new_seq;
    rx_old_data = rx_new_data;
    rx_old_valid = rx_new_valid;
    rx_old_ovr = rx_new_ovr;
    if (rx_new_seq == data_rx_ack) begin
      rx_new_seq = ~rx_new_seq;
      rx_new_data = b;
      rx_new_valid = stop;
    end else begin
      rx_new_ovr = 1'b1;
    end
    rx_lo = s + 1 + 9 * N;
    rx_hi = s + 1 + 10 * N + 3;
    rx = 1'b0;
    step(N);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      step(N);
    end
    rx = stop;
    step(N);
    rx = 1'b1;
    step(12);
  endtask

  // Request a TX frame; the start bit appears from the next edge.
  task automatic tx_request(input logic [7:0] b);
    if (tx_active) tx_prev_ack = tx_seqval;
    data_tx = b;
    data_tx_seq = ~data_tx_seq;
    tx_active = 1'b1;
    tx_start = cyc + 1;
    tx_byte = b;
    tx_seqval = data_tx_seq;
  endtask

  task automatic wait_tx_done(input int budget);
    int k;
    k = 0;
    while (data_tx_ack !== data_tx_seq && k < budget) begin
      step(1);
      k++;
    end
    checkOutput("tx_ack_timeout", 32'(data_tx_ack === data_tx_seq), 32'd1);
  endtask

  initial begin
    logic [9:0] wave;
    int t0;
    reset = 1'b1;
    rx = 1'b1;
    data_rx_ack = 1'b0;
    data_tx = 8'h00;
    data_tx_seq = 1'b0;
    do_reset(3);
    step(5);

    // Good frame 0xA5.
    t0 = seq_toggles;
    applyStimulus(8'hA5, 1'b1);
    checkOutput("a5_data", 32'(data_rx), 32'hA5);
    checkOutput("a5_valid", 32'(data_rx_valid), 32'd1);
    checkOutput("a5_toggles", 32'(seq_toggles - t0), 32'd1);
    data_rx_ack = data_rx_seq;

    // Framing error: 0x00 with the stop bit low is still published.
    t0 = seq_toggles;
    applyStimulus(8'h00, 1'b0);
    checkOutput("ferr_data", 32'(data_rx), 32'h00);
    checkOutput("ferr_valid", 32'(data_rx_valid), 32'd0);
    checkOutput("ferr_toggles", 32'(seq_toggles - t0), 32'd1);
    data_rx_ack = data_rx_seq;

    // Overrun: 0x11 left unacknowledged, then 0x22 is dropped.
    t0 = seq_toggles;
    applyStimulus(8'h11, 1'b1);
    checkOutput("ovr_first_data", 32'(data_rx), 32'h11);
    applyStimulus(8'h22, 1'b1);
    checkOutput("ovr_held_data", 32'(data_rx), 32'h11);
    checkOutput("ovr_flag", 32'(rx_overrun), 32'd1);
    checkOutput("ovr_toggles", 32'(seq_toggles - t0), 32'd1);
    data_rx_ack = data_rx_seq;
    step(4);
    applyStimulus(8'h33, 1'b1);
    checkOutput("after_ack_data", 32'(data_rx), 32'h33);
    checkOutput("ovr_sticky", 32'(rx_overrun), 32'd1);
    data_rx_ack = data_rx_seq;

    // Glitch: 4-cycle low pulse must be rejected at the start-bit sample.
    t0 = seq_toggles;
    rx = 1'b0;
    step(4);
    rx = 1'b1;
    step(30);
    checkOutput("glitch_toggles", 32'(seq_toggles - t0), 32'd0);
    checkOutput("glitch_idle", 32'(dut.rx_state), 32'(R_IDLE));

    // TX 0x8A (with data_tx changed mid-frame), back-to-back 0x3C, while an
    // RX frame 0x5A arrives concurrently.
    wave = 10'b1100010100;
    fork
      begin
        applyStimulus(8'h5A, 1'b1);
      end
      begin
        tx_request(8'h8A);
        step(1 + N / 2);
        for (int i = 0; i < 10; i++) begin
          checkOutput("tx_wave_bit", 32'(tx), 32'(wave[i]));
          if (i == 3) data_tx = 8'hFF;
          if (i < 9) step(N);
        end
        wait_tx_done(4 * N);
        tx_request(8'h3C);
        step(1);
        checkOutput("tx_b2b_start", 32'(tx), 32'd0);
        wait_tx_done(12 * N);
      end
    join
    checkOutput("conc_rx_data", 32'(data_rx), 32'h5A);
    checkOutput("conc_tx_ack", 32'(data_tx_ack == data_tx_seq), 32'd1);
    step(5);

    // Reset in the middle of a TX frame and an RX frame, with an unacked
    // RX byte and the overrun flag still set.
    tx_request(8'h77);
    step(3 * N);
    rx = 1'b0;
    step(2 * N);
    rx = 1'b1;
    step(2);
    checkOutput("pre_rst_tx_busy", 32'(data_tx_ack != data_tx_seq), 32'd1);
    checkOutput("pre_rst_rx_pending", 32'(data_rx_seq != data_rx_ack), 32'd1);
    do_reset(3);
    step(5);

    // Recovery after reset.
    applyStimulus(8'hC3, 1'b1);
    checkOutput("post_rst_data", 32'(data_rx), 32'hC3);
    checkOutput("post_rst_overrun", 32'(rx_overrun), 32'd0);
    tx_request(8'h01);
    wait_tx_done(12 * N);
    step(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
